// File: rtl/data_mem_controller_pkg.sv
// Shared types and encodings for the data memory controller.
package data_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size encodings
  localparam logic [1:0] SZ_SB = 2'b00;
  localparam logic [1:0] SZ_SH = 2'b01;
  localparam logic [1:0] SZ_SW = 2'b10;

endpackage

// File: rtl/data_mem_controller_if.sv
// Word-wide backend memory bus between the controller (master) and memory (slave).
interface data_mem_controller_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-3:0] MEM_ADDRESS;
  logic [31:0]           MEM_WRITEDATA;
  logic [3:0]            MEM_BYTEEN;
  logic [31:0]           MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTEEN,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTEEN,
    output MEM_READDATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/data_mem_load_align.sv
// Extracts the addressed byte/half/word lane from a backend word and extends it.
module data_mem_load_align
  import data_mem_controller_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0]        w_shifted;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_shifted = i_word >> {i_addr, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  // Select the extension rule from funct3; LW passes the word through
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage load/store responder: stalls the CPU while a multi-cycle word
// backend completes the access, places store lanes and extends load lanes.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            main_mem_read,
  input  logic [2:0]            main_mem_write,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           DATA_IN,
  output logic [31:0]           DATA_OUT,
  output logic                  BUSY_WAIT,
  output logic                  MEM_ERROR,
  data_mem_controller_if.master mem
);

  state_t                r_state, w_next;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [ADDR_WIDTH-3:0] r_word_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_byteen;
  logic [31:0]           r_data_out;
  logic                  r_mem_error;

  logic        w_is_store, w_is_load, w_request;
  logic        w_illegal, w_misaligned, w_error, w_legal, w_capture;
  logic [31:0] w_place_data;
  logic [3:0]  w_place_be;
  logic [31:0] w_load_result;

  // A store takes priority over a simultaneous load
  assign w_is_store = main_mem_write[2];
  assign w_is_load  = main_mem_read[3] & ~w_is_store;
  assign w_request  = w_is_store | w_is_load;

  // Classify the incoming request as illegal or misaligned
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (w_is_store) begin
      case (main_mem_write[1:0])
        SZ_SW:   w_misaligned = |ADDRESS[1:0];
        SZ_SH:   w_misaligned = ADDRESS[0];
        SZ_SB:   w_misaligned = 1'b0;
        default: w_illegal    = 1'b1;
      endcase
    end else if (w_is_load) begin
      case (main_mem_read[2:0])
        F3_LW:         w_misaligned = |ADDRESS[1:0];
        F3_LH, F3_LHU: w_misaligned = ADDRESS[0];
        F3_LB, F3_LBU: w_misaligned = 1'b0;
        default:       w_illegal    = 1'b1;
      endcase
    end
  end

  assign w_error = w_illegal | w_misaligned;
  assign w_legal = w_request & ~w_error;

  // Replicate store data across lanes and build the byte enables
  always_comb begin
    w_place_data = DATA_IN;
    w_place_be   = 4'b0000;
    if (w_is_store) begin
      case (main_mem_write[1:0])
        SZ_SB: begin
          w_place_data = {4{DATA_IN[7:0]}};
          w_place_be   = 4'b0001 << ADDRESS[1:0];
        end
        SZ_SH: begin
          w_place_data = {2{DATA_IN[15:0]}};
          w_place_be   = ADDRESS[1] ? 4'b1100 : 4'b0011;
        end
        default: w_place_be = 4'b1111;
      endcase
    end
  end

  // Next-state, stall and capture decode
  always_comb begin
    w_next    = r_state;
    BUSY_WAIT = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        BUSY_WAIT = w_legal;
        if (w_legal) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        BUSY_WAIT = 1'b1;
        if (!mem.MEM_BUSYWAIT) begin
          w_next    = ST_DONE;
          w_capture = ~r_is_store;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Latch legal requests, capture load results and register the error pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_word_addr <= '0;
      r_wdata     <= 32'h0;
      r_byteen    <= 4'b0000;
      r_data_out  <= 32'h0;
      r_mem_error <= 1'b0;
    end else begin
      r_mem_error <= (r_state == ST_IDLE) & w_request & w_error;
      if (r_state == ST_IDLE && w_legal) begin
        r_is_store  <= w_is_store;
        r_funct3    <= main_mem_read[2:0];
        r_addr_lo   <= ADDRESS[1:0];
        r_word_addr <= ADDRESS[ADDR_WIDTH-1:2];
        r_wdata     <= w_place_data;
        r_byteen    <= w_place_be;
      end
      if (w_capture) r_data_out <= w_load_result;
    end
  end

  data_mem_load_align u_load_align (
    .i_word   (mem.MEM_READDATA),
    .i_addr   (r_addr_lo),
    .i_funct3 (r_funct3),
    .o_data   (w_load_result)
  );

  assign mem.MEM_READ      = (r_state == ST_ACCESS) & ~r_is_store;
  assign mem.MEM_WRITE     = (r_state == ST_ACCESS) & r_is_store;
  assign mem.MEM_ADDRESS   = r_word_addr;
  assign mem.MEM_WRITEDATA = r_wdata;
  assign mem.MEM_BYTEEN    = r_byteen;
  assign DATA_OUT          = r_data_out;
  assign MEM_ERROR         = r_mem_error;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed self-checking bench for data_mem_controller.
module tb_data_mem_controller;
  import data_mem_controller_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    rd;
  logic [2:0]    wr;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic          busy;
  logic          merr;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_controller_if #(.ADDR_WIDTH(AW)) mif ();

  data_mem_controller #(.ADDR_WIDTH(AW)) dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .main_mem_read  (rd),
    .main_mem_write (wr),
    .ADDRESS        (addr),
    .DATA_IN        (din),
    .DATA_OUT       (dout),
    .BUSY_WAIT      (busy),
    .MEM_ERROR      (merr),
    .mem            (mif)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 4'b0; wr = 3'b0; addr = '0; din = 32'h0;
    mif.MEM_READDATA = 32'h0; mif.MEM_BUSYWAIT = 1'b0;
    #3;
    n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 00000000", dout); end
    n_cmp++; if (merr !== 1'b0) begin n_bad++; $display("FAIL rst_merr: got %b want 0", merr); end
    n_cmp++; if ({mif.MEM_READ, mif.MEM_WRITE} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {mif.MEM_READ, mif.MEM_WRITE}); end
    n_cmp++; if (mif.MEM_ADDRESS !== 30'h0) begin n_bad++; $display("FAIL rst_maddr: got %h want 0", mif.MEM_ADDRESS); end
    n_cmp++; if (mif.MEM_WRITEDATA !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mif.MEM_WRITEDATA); end
    n_cmp++; if (mif.MEM_BYTEEN !== 4'b0000) begin n_bad++; $display("FAIL rst_byteen: got %b want 0000", mif.MEM_BYTEEN); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_word();
    tick();
    rd = 4'b1010; addr = 32'h0000_0010;
    mif.MEM_READDATA = 32'hDEAD_BEEF; mif.MEM_BUSYWAIT = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lw_busy_c0: got %b want 1", busy); end
    n_cmp++; if (mif.MEM_READ !== 1'b0) begin n_bad++; $display("FAIL lw_read_c0: got %b want 0", mif.MEM_READ); end
    tick(); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lw_busy_c1: got %b want 1", busy); end
    n_cmp++; if (mif.MEM_READ !== 1'b1) begin n_bad++; $display("FAIL lw_read_c1: got %b want 1", mif.MEM_READ); end
    n_cmp++; if (mif.MEM_WRITE !== 1'b0) begin n_bad++; $display("FAIL lw_write_c1: got %b want 0", mif.MEM_WRITE); end
    n_cmp++; if (mif.MEM_ADDRESS !== 30'h4) begin n_bad++; $display("FAIL lw_maddr: got %h want 4", mif.MEM_ADDRESS); end
    tick(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lw_busy_c2: got %b want 0", busy); end
    n_cmp++; if (mif.MEM_READ !== 1'b0) begin n_bad++; $display("FAIL lw_read_c2: got %b want 0", mif.MEM_READ); end
    n_cmp++; if (dout !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_dout: got %h want deadbeef", dout); end
    rd = 4'b0;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [5] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LB};
    logic [31:0] ad  [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h12};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      int n;
      tick();
      rd = {1'b1, f3[i]}; addr = ad[i];
      mif.MEM_READDATA = 32'h80FF_0000; mif.MEM_BUSYWAIT = 1'b0;
      #1;
      n = 0;
      while (busy && n < 20) begin tick(); #1; n++; end
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL ext_stall[%0d]: got %0d want 2", i, n); end
      n_cmp++; if (dout !== exp[i]) begin n_bad++; $display("FAIL ext_dout[%0d]: got %h want %h", i, dout, exp[i]); end
      rd = 4'b0;
    end
  endtask

  task automatic test_store();
    logic [2:0]  wv [3] = '{3'b100, 3'b101, 3'b110};
    logic [31:0] ad [3] = '{32'h21, 32'h22, 32'h24};
    logic [3:0]  be [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wd [3] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h1234_56AB};
    logic [29:0] wa [3] = '{30'h8, 30'h8, 30'h9};
    for (int i = 0; i < 3; i++) begin
      tick();
      wr = wv[i]; addr = ad[i]; din = 32'h1234_56AB; mif.MEM_BUSYWAIT = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL st_busy_c0[%0d]: got %b want 1", i, busy); end
      tick(); #1;
      n_cmp++; if ({mif.MEM_WRITE, mif.MEM_READ} !== 2'b10) begin n_bad++; $display("FAIL st_strobes[%0d]: got %b want 10", i, {mif.MEM_WRITE, mif.MEM_READ}); end
      n_cmp++; if (mif.MEM_BYTEEN !== be[i]) begin n_bad++; $display("FAIL st_byteen[%0d]: got %b want %b", i, mif.MEM_BYTEEN, be[i]); end
      n_cmp++; if (mif.MEM_WRITEDATA !== wd[i]) begin n_bad++; $display("FAIL st_wdata[%0d]: got %h want %h", i, mif.MEM_WRITEDATA, wd[i]); end
      n_cmp++; if (mif.MEM_ADDRESS !== wa[i]) begin n_bad++; $display("FAIL st_maddr[%0d]: got %h want %h", i, mif.MEM_ADDRESS, wa[i]); end
      tick(); #1;
      n_cmp++; if ({busy, mif.MEM_WRITE} !== 2'b00) begin n_bad++; $display("FAIL st_done[%0d]: got %b want 00", i, {busy, mif.MEM_WRITE}); end
      n_cmp++; if (dout !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL st_dout_kept[%0d]: got %h want ffffffff", i, dout); end
      wr = 3'b0;
    end
  endtask

  task automatic test_errors();
    logic [3:0]  rv [5] = '{4'b1010, 4'b1011, 4'b0000, 4'b1001, 4'b0000};
    logic [2:0]  wv [5] = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b101};
    logic [31:0] ad [5] = '{32'h02, 32'h00, 32'h00, 32'h01, 32'h03};
    for (int i = 0; i < 5; i++) begin
      tick();
      rd = rv[i]; wr = wv[i]; addr = ad[i];
      #1;
      n_cmp++; if ({busy, merr} !== 2'b00) begin n_bad++; $display("FAIL err_c0[%0d]: busy,err got %b want 00", i, {busy, merr}); end
      tick();
      rd = 4'b0; wr = 3'b0;
      #1;
      n_cmp++; if (merr !== 1'b1) begin n_bad++; $display("FAIL err_pulse[%0d]: got %b want 1", i, merr); end
      n_cmp++; if ({mif.MEM_READ, mif.MEM_WRITE, busy} !== 3'b000) begin n_bad++; $display("FAIL err_strobes[%0d]: got %b want 000", i, {mif.MEM_READ, mif.MEM_WRITE, busy}); end
      tick(); #1;
      n_cmp++; if (merr !== 1'b0) begin n_bad++; $display("FAIL err_clear[%0d]: got %b want 0", i, merr); end
    end
  endtask

  task automatic test_wait_states();
    int k, stall, nread;
    tick();
    rd = 4'b1010; addr = 32'h30;
    mif.MEM_READDATA = 32'hCAFE_F00D; mif.MEM_BUSYWAIT = 1'b1;
    #1;
    k = 0; stall = 0; nread = 0;
    while (busy && k < 30) begin
      stall++;
      tick(); k++;
      mif.MEM_BUSYWAIT = (k <= 5);
      #1;
      if (mif.MEM_READ) nread++;
    end
    n_cmp++; if (stall !== 7) begin n_bad++; $display("FAIL wait_stall: got %0d want 7", stall); end
    n_cmp++; if (nread !== 6) begin n_bad++; $display("FAIL wait_read_cycles: got %0d want 6", nread); end
    n_cmp++; if (dout !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wait_dout: got %h want cafef00d", dout); end
    rd = 4'b0; mif.MEM_BUSYWAIT = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    tick();
    rd = 4'b1010; addr = 32'h40;
    mif.MEM_READDATA = 32'h1111_2222; mif.MEM_BUSYWAIT = 1'b1;
    tick(); tick(); tick(); #1;
    n_cmp++; if ({busy, mif.MEM_READ} !== 2'b11) begin n_bad++; $display("FAIL rma_pre: got %b want 11", {busy, mif.MEM_READ}); end
    rst_n = 1'b0; rd = 4'b0;
    #1;
    n_cmp++; if ({busy, mif.MEM_READ} !== 2'b00) begin n_bad++; $display("FAIL rma_strobe: got %b want 00", {busy, mif.MEM_READ}); end
    n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL rma_dout: got %h want 0", dout); end
    n_cmp++; if (mif.MEM_ADDRESS !== 30'h0) begin n_bad++; $display("FAIL rma_maddr: got %h want 0", mif.MEM_ADDRESS); end
    mif.MEM_BUSYWAIT = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); #1;
    n_cmp++; if ({busy, mif.MEM_READ, dout} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL rma_after: got %b/%b/%h want 0/0/0", busy, mif.MEM_READ, dout); end
  endtask

  task automatic test_store_wins();
    tick();
    rd = 4'b1010; wr = 3'b110; addr = 32'h40; din = 32'hA5A5_A5A5;
    mif.MEM_READDATA = 32'h9999_9999; mif.MEM_BUSYWAIT = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_busy_c0: got %b want 1", busy); end
    tick(); #1;
    n_cmp++; if ({mif.MEM_WRITE, mif.MEM_READ} !== 2'b10) begin n_bad++; $display("FAIL sw_strobes: got %b want 10", {mif.MEM_WRITE, mif.MEM_READ}); end
    n_cmp++; if (mif.MEM_WRITEDATA !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sw_wdata: got %h want a5a5a5a5", mif.MEM_WRITEDATA); end
    n_cmp++; if (mif.MEM_BYTEEN !== 4'b1111) begin n_bad++; $display("FAIL sw_byteen: got %b want 1111", mif.MEM_BYTEEN); end
    n_cmp++; if (mif.MEM_ADDRESS !== 30'h10) begin n_bad++; $display("FAIL sw_maddr: got %h want 10", mif.MEM_ADDRESS); end
    tick(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sw_busy_c2: got %b want 0", busy); end
    n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL sw_dout: got %h want 0", dout); end
    rd = 4'b0; wr = 3'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_errors();
    test_wait_states();
    test_reset_mid_access();
    test_store_wins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "timeout");
  end

endmodule
